// File: rtl/i2c_arb_pkg.sv
// ---------------------------------------------------------------------------
// i2c_arb_pkg
// Shared definitions for the I2C bus arbiter: FSM state encoding, payload
// field widths, the latched command record and a saturating counter helper.
// ---------------------------------------------------------------------------
package i2c_arb_pkg;

  localparam int ADR_W   = 7;
  localparam int DATA_W  = 32;
  localparam int BYTES_W = 3;
  localparam int CH_W    = 4;
  localparam int CNT_W   = 32;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    WAIT_START = 3'd2,
    WAIT_DONE  = 3'd3,
    DONE       = 3'd4
  } arb_state_e;

  // Command captured from the winning requester at grant time.
  typedef struct packed {
    logic               rd;
    logic [ADR_W-1:0]   adr;
    logic [DATA_W-1:0]  wr_data;
    logic [BYTES_W-1:0] wr_bytes;
    logic [BYTES_W-1:0] rd_bytes;
    logic [CH_W-1:0]    rd_channels;
  } cmd_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. Searches req_i starting at
// rr_ptr_i+1 (modulo N_REQ) and reports the first asserted index.
//
// Ports
//   req_i     in  N_REQ  request vector
//   rr_ptr_i  in  IDX_W  index of the previous winner
//   winner_o  out IDX_W  selected requester (0 when valid_o is low)
//   valid_o   out 1      at least one request is asserted
// ---------------------------------------------------------------------------
module rr_picker #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest candidate to the nearest one so that the last hit
  // written (the nearest to rr_ptr_i+1) has the highest priority.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise the tool infers a latch.
    winner_o = '0;
    valid_o  = 1'b0;
    cand     = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      cand = IDX_W'((int'(rr_ptr_i) + off) % N_REQ);
      if (req_i[cand]) begin
        winner_o = cand;
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_bus_arbiter
// Shares one i2c_master_if between N_REQ requesters. Round-robin grant,
// latches the winner's command, issues a single wr/rd start pulse, follows
// the master's busy to completion (with start and transfer timeouts) and
// routes read-data strobes back to the current owner.
//
// Ports
//   clk, reset            40 MHz clock, synchronous active-high reset
//   req/req_rd/req_*      per-requester level request and payload slices
//   gnt                   one-hot owner, held for the whole transaction
//   done, err             completion pulse to owner; err=1 means timeout
//   rd_data, rd_data_en   registered read data and per-owner strobe
//   m_wr_flg, m_rd_flg    one-cycle start pulses to the master
//   m_adr .. m_rd_channels latched command fields to the master
//   m_rd_data(_en), m_busy read data, strobe and busy from the master
//   busy                  arbiter is not idle
// ---------------------------------------------------------------------------
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int          N_REQ    = 2,
  parameter int unsigned START_TO = 64,
  parameter int unsigned XFER_TO  = 4000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_rd,
  input  logic [ADR_W*N_REQ-1:0]   req_adr,
  input  logic [DATA_W*N_REQ-1:0]  req_wr_data,
  input  logic [BYTES_W*N_REQ-1:0] req_wr_bytes,
  input  logic [BYTES_W*N_REQ-1:0] req_rd_bytes,
  input  logic [CH_W*N_REQ-1:0]    req_rd_channels,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         done,
  output logic                     err,
  output logic [DATA_W-1:0]        rd_data,
  output logic [N_REQ-1:0]         rd_data_en,
  output logic                     m_wr_flg,
  output logic                     m_rd_flg,
  output logic [ADR_W-1:0]         m_adr,
  output logic [DATA_W-1:0]        m_wr_data,
  output logic [BYTES_W-1:0]       m_wr_bytes,
  output logic [BYTES_W-1:0]       m_rd_bytes,
  output logic [CH_W-1:0]          m_rd_channels,
  input  logic [DATA_W-1:0]        m_rd_data,
  input  logic                     m_rd_data_en,
  input  logic                     m_busy,
  output logic                     busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE       = N_REQ'(1);
  localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_TO - 1);
  localparam logic [CNT_W-1:0] XFER_LIM  = CNT_W'(XFER_TO - 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  cmd_t              cmd_q;
  logic [N_REQ-1:0]  gnt_q;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rd_data_q;
  logic [N_REQ-1:0]  rd_data_en_q;

  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  cmd_t              pick_cmd;
  logic              grant;
  logic              route_ok;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_picker (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .winner_o (pick_idx),
    .valid_o  (pick_valid)
  );

  // Payload mux; loop with constant slice positions instead of a computed
  // part-select base.
  always_comb begin
    pick_cmd = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (i == int'(pick_idx)) begin
        pick_cmd.rd          = req_rd[i];
        pick_cmd.adr         = req_adr[i*ADR_W +: ADR_W];
        pick_cmd.wr_data     = req_wr_data[i*DATA_W +: DATA_W];
        pick_cmd.wr_bytes    = req_wr_bytes[i*BYTES_W +: BYTES_W];
        pick_cmd.rd_bytes    = req_rd_bytes[i*BYTES_W +: BYTES_W];
        pick_cmd.rd_channels = req_rd_channels[i*CH_W +: CH_W];
      end
    end
  end

  assign grant    = (state_q == IDLE) && pick_valid;
  assign route_ok = (state_q == WAIT_START) || (state_q == WAIT_DONE) ||
                    (state_q == DONE);

  // Next-state logic. The timeout counter is cleared on entry to each wait
  // state so each phase gets its own full budget.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (m_busy) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (cnt_q == START_LIM) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      WAIT_DONE: begin
        if (!m_busy) begin
          state_d = DONE;
        end else if (cnt_q == XFER_LIM) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= IDX_W'(N_REQ - 1);
      cnt_q        <= '0;
      // NOTE: the command registers drive outputs directly, so they are
      // reset as well; these are plain flops, not a RAM.
      cmd_q        <= '0;
      gnt_q        <= '0;
      err_q        <= 1'b0;
      rd_data_q    <= '0;
      rd_data_en_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // err_d is only ever set on the edge into DONE, so err is a one-cycle
      // qualifier aligned with done.
      err_q   <= err_d;

      if (grant) begin
        cmd_q    <= pick_cmd;
        gnt_q    <= ONE << pick_idx;
        rr_ptr_q <= pick_idx;
      end else if (state_q == DONE) begin
        gnt_q <= '0;
      end

      // gnt_q is stable from ISSUE through DONE, so it doubles as the
      // owner mask for read-strobe routing.
      if (m_rd_data_en && route_ok) begin
        rd_data_q    <= m_rd_data;
        rd_data_en_q <= gnt_q;
      end else begin
        rd_data_en_q <= '0;
      end
    end
  end

  assign gnt           = gnt_q;
  assign done          = (state_q == DONE) ? gnt_q : '0;
  assign err           = err_q;
  assign rd_data       = rd_data_q;
  assign rd_data_en    = rd_data_en_q;
  assign m_wr_flg      = (state_q == ISSUE) && !cmd_q.rd;
  assign m_rd_flg      = (state_q == ISSUE) &&  cmd_q.rd;
  assign m_adr         = cmd_q.adr;
  assign m_wr_data     = cmd_q.wr_data;
  assign m_wr_bytes    = cmd_q.wr_bytes;
  assign m_rd_bytes    = cmd_q.rd_bytes;
  assign m_rd_channels = cmd_q.rd_channels;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_bus_arbiter
// Self-checking bench for i2c_bus_arbiter with N_REQ=2, START_TO=64,
// XFER_TO=1000. A small master model drives m_busy / m_rd_data_en; the
// expected winner comes from a round-robin reference kept as a plain index.
// ---------------------------------------------------------------------------
module tb_i2c_bus_arbiter;

  localparam int N        = 2;
  localparam int START_TO = 64;
  localparam int XFER_TO  = 1000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]    req, req_rd;
  logic [7*N-1:0]  req_adr;
  logic [32*N-1:0] req_wr_data;
  logic [3*N-1:0]  req_wr_bytes, req_rd_bytes;
  logic [4*N-1:0]  req_rd_channels;
  logic [N-1:0]    gnt, done, rd_data_en;
  logic            err, m_wr_flg, m_rd_flg, busy;
  logic [31:0]     rd_data, m_wr_data, m_rd_data;
  logic [6:0]      m_adr;
  logic [2:0]      m_wr_bytes, m_rd_bytes;
  logic [3:0]      m_rd_channels;
  logic            m_rd_data_en, m_busy;

  logic [6:0]  adr_a [N];
  logic [31:0] wd_a  [N];
  logic [2:0]  wb_a  [N];
  logic [2:0]  rb_a  [N];
  logic [3:0]  ch_a  [N];

  always_comb begin
    req_adr = '0; req_wr_data = '0; req_wr_bytes = '0;
    req_rd_bytes = '0; req_rd_channels = '0;
    for (int i = 0; i < N; i++) begin
      req_adr[i*7 +: 7]          = adr_a[i];
      req_wr_data[i*32 +: 32]    = wd_a[i];
      req_wr_bytes[i*3 +: 3]     = wb_a[i];
      req_rd_bytes[i*3 +: 3]     = rb_a[i];
      req_rd_channels[i*4 +: 4]  = ch_a[i];
    end
  end

  i2c_bus_arbiter #(
    .N_REQ(N), .START_TO(START_TO), .XFER_TO(XFER_TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req(req), .req_rd(req_rd), .req_adr(req_adr), .req_wr_data(req_wr_data),
    .req_wr_bytes(req_wr_bytes), .req_rd_bytes(req_rd_bytes),
    .req_rd_channels(req_rd_channels),
    .gnt(gnt), .done(done), .err(err), .rd_data(rd_data), .rd_data_en(rd_data_en),
    .m_wr_flg(m_wr_flg), .m_rd_flg(m_rd_flg), .m_adr(m_adr), .m_wr_data(m_wr_data),
    .m_wr_bytes(m_wr_bytes), .m_rd_bytes(m_rd_bytes), .m_rd_channels(m_rd_channels),
    .m_rd_data(m_rd_data), .m_rd_data_en(m_rd_data_en), .m_busy(m_busy),
    .busy(busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rr_m;
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
  logic [31:0]  rd_q[$];
  logic [N-1:0] rdm_q[$];
  int busy_rise_cyc, busy_fall_cyc;
  logic [31:0] strobe_base;
  logic [6:0]  cap_adr;
  logic [31:0] cap_wd;
  logic [2:0]  cap_wb, cap_rb;
  logic [3:0]  cap_ch;
  logic        cap_wr, cap_rd;
  logic [N-1:0] cap_done;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_wr_flg) wr_cnt <= wr_cnt + 1;
    if (m_rd_flg) rd_cnt <= rd_cnt + 1;
    if (|done) done_cnt <= done_cnt + 1;
    if (rd_data_en != '0) begin
      rd_q.push_back(rd_data);
      rdm_q.push_back(rd_data_en);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  // Reference arbitration: first requesting index after the last winner.
  function automatic int model_pick(input logic [N-1:0] m);
    int i;
    for (int k = 1; k <= N; k++) begin
      i = (rr_m + k) % N;
      if (m[i]) return i;
    end
    return -1;
  endfunction

  task automatic rand_payload(input int i);
    adr_a[i] = 7'($urandom);
    wd_a[i]  = $urandom;
    wb_a[i]  = 3'($urandom);
    rb_a[i]  = 3'($urandom);
    ch_a[i]  = 4'($urandom);
  endtask

  // Master model for one transaction. busy_delay<0: busy never rises.
  // busy_len<0: busy stays high until done. Returns ok=0 on an expired bound.
  task automatic serve(input int busy_delay, input int busy_len, input int nstb,
                       input bit drop, output int own, output bit e,
                       output int flag_cyc, output int done_cyc, output bit ok);
    int n;
    int k;
    ok = 1'b0; own = -1; e = 1'b0; flag_cyc = -1; done_cyc = -1; cap_done = '0;
    n = 0;
    while (!(m_wr_flg || m_rd_flg) && n < 20) begin @(negedge clk); n++; end
    if (!(m_wr_flg || m_rd_flg)) return;
    flag_cyc = cyc;
    for (int i = 0; i < N; i++) if (gnt[i]) own = i;
    cap_wr = m_wr_flg; cap_rd = m_rd_flg; cap_adr = m_adr; cap_wd = m_wr_data;
    cap_wb = m_wr_bytes; cap_rb = m_rd_bytes; cap_ch = m_rd_channels;
    if (busy_delay >= 0) begin
      repeat (busy_delay) @(negedge clk);
      m_busy = 1'b1;
      busy_rise_cyc = cyc;
      if (busy_len >= 0) begin
        k = 0;
        for (int i = 0; i < busy_len; i++) begin
          @(negedge clk);
          if (i % 2 == 0 && k < nstb) begin
            m_rd_data_en = 1'b1;
            m_rd_data    = strobe_base + 32'(k);
            k++;
          end else begin
            m_rd_data_en = 1'b0;
          end
        end
        @(negedge clk);
        m_rd_data_en = 1'b0;
        m_busy = 1'b0;
        busy_fall_cyc = cyc;
      end
    end
    n = 0;
    while (done == '0 && n < 3000) begin @(negedge clk); n++; end
    m_busy = 1'b0;
    m_rd_data_en = 1'b0;
    if (done == '0) return;
    done_cyc = cyc;
    e = err;
    cap_done = done;
    if (drop && own >= 0) req[own] = 1'b0;
    ok = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (gnt !== '0) begin bad++; $display("FAIL reset_gnt: got %b expected 0", gnt); end
    total++; if (done !== '0) begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b expected 0", err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++; if ({m_wr_flg, m_rd_flg} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b expected 00", {m_wr_flg, m_rd_flg}); end
    total++; if (m_adr !== '0 || m_wr_data !== '0) begin bad++; $display("FAIL reset_payload: got adr=%h data=%h expected 0", m_adr, m_wr_data); end
    total++; if (rd_data_en !== '0 || rd_data !== '0) begin bad++; $display("FAIL reset_rd: got en=%b data=%h expected 0", rd_data_en, rd_data); end
    reset = 1'b0;
    rr_m = N - 1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0 || gnt !== '0) begin bad++; $display("FAIL idle_no_req: got busy=%b gnt=%b expected 0", busy, gnt); end
  endtask

  task automatic test_contention();
    int own, fc, dc, exp;
    bit e, ok;
    for (int i = 0; i < N; i++) begin rand_payload(i); req_rd[i] = 1'($urandom); end
    req = '1;
    for (int t = 0; t < 2; t++) begin
      exp = model_pick(req);
      rr_m = exp;
      serve(1, 5, 0, 1'b1, own, e, fc, dc, ok);
      total++; if (!ok || own !== exp) begin bad++; $display("FAIL contention_order%0d: got owner %0d expected %0d", t, own, exp); end
      total++; if (cap_adr !== adr_a[exp] || cap_rd !== req_rd[exp]) begin bad++; $display("FAIL contention_payload%0d: got adr=%h rd=%b expected adr=%h rd=%b", t, cap_adr, cap_rd, adr_a[exp], req_rd[exp]); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int own, fc, dc, exp, prev_dc;
    bit e, ok;
    prev_dc = -1;
    req = '1;
    for (int t = 0; t < 4; t++) begin
      exp = model_pick(req);
      rr_m = exp;
      serve(1, 4, 0, 1'b0, own, e, fc, dc, ok);
      total++; if (!ok || own !== exp) begin bad++; $display("FAIL alternate%0d: got owner %0d expected %0d", t, own, exp); end
      if (t > 0) begin
        total++; if (fc - prev_dc !== 2) begin bad++; $display("FAIL turnaround%0d: got %0d cycles expected 2", t, fc - prev_dc); end
      end
      prev_dc = dc;
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    int own, fc, dc, exp, rise, wr0, rd0;
    bit e, ok;
    adr_a[0] = 7'h35; wd_a[0] = 32'h000000D2; wb_a[0] = 3'd1; rb_a[0] = '0; ch_a[0] = '0;
    req_rd[0] = 1'b0;
    wr0 = wr_cnt; rd0 = rd_cnt;
    req[0] = 1'b1;
    rise = cyc;
    exp = model_pick(req);
    rr_m = exp;
    serve(1, 200, 0, 1'b1, own, e, fc, dc, ok);
    total++; if (!ok || own !== exp) begin bad++; $display("FAIL write_owner: got %0d expected %0d", own, exp); end
    total++; if (fc - rise !== 1) begin bad++; $display("FAIL write_latency: got %0d expected 1", fc - rise); end
    total++; if (cap_wr !== 1'b1 || cap_rd !== 1'b0) begin bad++; $display("FAIL write_flag: got wr=%b rd=%b expected wr=1 rd=0", cap_wr, cap_rd); end
    total++; if (cap_adr !== 7'h35 || cap_wd !== 32'hD2 || cap_wb !== 3'd1) begin bad++; $display("FAIL write_payload: got adr=%h data=%h bytes=%0d expected 35/d2/1", cap_adr, cap_wd, cap_wb); end
    total++; if (dc - busy_fall_cyc !== 1) begin bad++; $display("FAIL write_done_delay: got %0d expected 1", dc - busy_fall_cyc); end
    total++; if (e !== 1'b0 || cap_done !== 2'b01) begin bad++; $display("FAIL write_done: got err=%b done=%b expected 0/01", e, cap_done); end
    @(negedge clk);
    total++; if (wr_cnt - wr0 !== 1 || rd_cnt - rd0 !== 0) begin bad++; $display("FAIL write_pulses: got wr=%0d rd=%0d expected 1/0", wr_cnt - wr0, rd_cnt - rd0); end
    total++; if (gnt !== '0 || busy !== 1'b0) begin bad++; $display("FAIL write_release: got gnt=%b busy=%b expected 0/0", gnt, busy); end
    total++; if (m_adr !== 7'h35) begin bad++; $display("FAIL write_hold: got adr=%h expected 35", m_adr); end
  endtask

  task automatic test_read_routing();
    int own, fc, dc, exp;
    bit e, ok;
    rand_payload(1);
    req_rd[1] = 1'b1; ch_a[1] = 4'd4; rb_a[1] = 3'd2;
    strobe_base = 32'd1;
    rd_q.delete(); rdm_q.delete();
    req[1] = 1'b1;
    exp = model_pick(req);
    rr_m = exp;
    serve(1, 12, 4, 1'b1, own, e, fc, dc, ok);
    total++; if (!ok || own !== exp) begin bad++; $display("FAIL read_owner: got %0d expected %0d", own, exp); end
    total++; if (cap_rd !== 1'b1 || cap_wr !== 1'b0 || cap_ch !== 4'd4 || cap_rb !== 3'd2) begin bad++; $display("FAIL read_cmd: got rd=%b wr=%b ch=%0d bytes=%0d expected 1/0/4/2", cap_rd, cap_wr, cap_ch, cap_rb); end
    total++; if (rd_q.size() !== 4) begin bad++; $display("FAIL read_count: got %0d expected 4", rd_q.size()); end
    for (int k = 0; k < rd_q.size() && k < 4; k++) begin
      total++; if (rd_q[k] !== 32'(k + 1) || rdm_q[k] !== 2'b10) begin bad++; $display("FAIL read_strobe%0d: got data=%0d en=%b expected %0d/10", k, rd_q[k], rdm_q[k], k + 1); end
    end
    req_rd[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start_timeout();
    int own, fc, dc, exp;
    bit e, ok;
    rand_payload(1); req_rd[1] = 1'b0;
    req[1] = 1'b1;
    exp = model_pick(req);
    rr_m = exp;
    serve(-1, 0, 0, 1'b1, own, e, fc, dc, ok);
    total++; if (!ok || e !== 1'b1) begin bad++; $display("FAIL start_to_err: got ok=%b err=%b expected 1/1", ok, e); end
    total++; if (dc - fc !== START_TO + 1) begin bad++; $display("FAIL start_to_delay: got %0d expected %0d", dc - fc, START_TO + 1); end
    total++; if (cap_done !== (2'b01 << exp)) begin bad++; $display("FAIL start_to_done: got %b expected owner %0d", cap_done, exp); end
    rand_payload(0); req_rd[0] = 1'b0;
    req[0] = 1'b1;
    exp = model_pick(req);
    rr_m = exp;
    serve(2, 5, 0, 1'b1, own, e, fc, dc, ok);
    total++; if (!ok || own !== exp || e !== 1'b0) begin bad++; $display("FAIL after_start_to: got owner=%0d err=%b expected %0d/0", own, e, exp); end
    @(negedge clk);
  endtask

  task automatic test_xfer_timeout();
    int own, fc, dc, exp;
    bit e, ok;
    rand_payload(0); req_rd[0] = 1'b0;
    req[0] = 1'b1;
    exp = model_pick(req);
    rr_m = exp;
    serve(1, -1, 0, 1'b1, own, e, fc, dc, ok);
    total++; if (!ok || own !== exp || e !== 1'b1) begin bad++; $display("FAIL xfer_to_err: got ok=%b owner=%0d err=%b expected 1/%0d/1", ok, own, e, exp); end
    total++; if (dc - busy_rise_cyc !== XFER_TO + 1) begin bad++; $display("FAIL xfer_to_delay: got %0d expected %0d", dc - busy_rise_cyc, XFER_TO + 1); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int own, fc, dc, exp, n, d0;
    bit e, ok;
    rand_payload(0); req_rd[0] = 1'b0;
    req = 2'b01;
    rr_m = 0;
    n = 0;
    while (!m_wr_flg && n < 20) begin @(negedge clk); n++; end
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL midrst_grant: got %b expected 01", gnt); end
    @(negedge clk);
    m_busy = 1'b1;
    repeat (6) @(negedge clk);
    d0 = done_cnt;
    reset = 1'b1; m_busy = 1'b0; req = '0;
    @(negedge clk);
    total++; if (gnt !== '0 || busy !== 1'b0 || done !== '0) begin bad++; $display("FAIL midrst_abort: got gnt=%b busy=%b done=%b expected 0", gnt, busy, done); end
    reset = 1'b0;
    rr_m = N - 1;
    repeat (5) @(negedge clk);
    total++; if (done_cnt !== d0) begin bad++; $display("FAIL midrst_no_done: got %0d pulses expected 0", done_cnt - d0); end
    // Last owner was 0: without the pointer reset requester 1 would win here.
    for (int i = 0; i < N; i++) begin rand_payload(i); req_rd[i] = 1'b0; end
    req = '1;
    exp = model_pick(req);
    rr_m = exp;
    serve(1, 3, 0, 1'b1, own, e, fc, dc, ok);
    total++; if (!ok || own !== exp) begin bad++; $display("FAIL midrst_rr: got owner %0d expected %0d", own, exp); end
    exp = model_pick(req);
    rr_m = exp;
    serve(1, 3, 0, 1'b1, own, e, fc, dc, ok);
    total++; if (!ok || own !== exp) begin bad++; $display("FAIL midrst_next: got owner %0d expected %0d", own, exp); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int own, fc, dc, exp, nstb;
    bit e, ok;
    logic [N-1:0] newm;
    for (int it = 0; it < 16; it++) begin
      newm = N'($urandom);
      if (newm == '0) newm[$urandom_range(0, N-1)] = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (newm[i] && !req[i]) begin rand_payload(i); req_rd[i] = 1'($urandom); end
      end
      req = req | newm;
      exp = model_pick(req);
      rr_m = exp;
      nstb = req_rd[exp] ? $urandom_range(0, 3) : 0;
      strobe_base = $urandom;
      rd_q.delete(); rdm_q.delete();
      serve($urandom_range(1, 3), $urandom_range(8, 20), nstb, 1'b1, own, e, fc, dc, ok);
      total++; if (!ok || own !== exp || e !== 1'b0) begin bad++; $display("FAIL rand%0d_owner: got owner=%0d err=%b expected %0d/0", it, own, e, exp); end
      total++; if (cap_adr !== adr_a[exp] || cap_wd !== wd_a[exp] || cap_wb !== wb_a[exp] || cap_rb !== rb_a[exp] || cap_ch !== ch_a[exp]) begin bad++; $display("FAIL rand%0d_payload: got adr=%h data=%h expected adr=%h data=%h", it, cap_adr, cap_wd, adr_a[exp], wd_a[exp]); end
      total++; if (cap_rd !== req_rd[exp] || cap_wr !== !req_rd[exp]) begin bad++; $display("FAIL rand%0d_flag: got rd=%b wr=%b expected rd=%b", it, cap_rd, cap_wr, req_rd[exp]); end
      total++; if (dc - busy_fall_cyc !== 1) begin bad++; $display("FAIL rand%0d_done_delay: got %0d expected 1", it, dc - busy_fall_cyc); end
      total++; if (rd_q.size() !== nstb) begin bad++; $display("FAIL rand%0d_strobes: got %0d expected %0d", it, rd_q.size(), nstb); end
      for (int k = 0; k < rd_q.size() && k < nstb; k++) begin
        total++; if (rd_q[k] !== strobe_base + 32'(k) || rdm_q[k] !== (2'b01 << exp)) begin bad++; $display("FAIL rand%0d_rd%0d: got data=%h en=%b expected %h owner %0d", it, k, rd_q[k], rdm_q[k], strobe_base + 32'(k), exp); end
      end
    end
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    req = '0; req_rd = '0;
    m_rd_data = '0; m_rd_data_en = 1'b0; m_busy = 1'b0;
    strobe_base = '0;
    for (int i = 0; i < N; i++) begin
      adr_a[i] = '0; wd_a[i] = '0; wb_a[i] = '0; rb_a[i] = '0; ch_a[i] = '0;
    end
    rr_m = N - 1;
    test_reset();
    test_contention();
    test_back_to_back();
    test_single_write();
    test_read_routing();
    test_start_timeout();
    test_xfer_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
